u_rec_gen2: RTL and testbench
=============================

// Module: u_rec_gen2
// PURPOSE
//  Parametrised UART receiver: recovers serial frames of DATA_BITS data bits, optional parity, and 1 or 2 stop bits.
//  It oversamples by OVERSAMPLE ticks of an external baud-rate enable and reports framing, parity and overrun errors.
//  Delivers each word through a valid/ready holding register toward the host-side FIFO/register block.
//  Replaces the fixed 8N1 receiver that runs at sys_clk rate.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, sent LSB first
//  OVERSAMPLE  16  baud_tickH pulses per bit, legal even 8..32
//  PARITY_EN   0   1 = parity bit follows the data bits
//  PARITY_ODD  0   1 = odd parity, 0 = even; ignored when PARITY_EN=0
//  STOP_BITS   1   stop bits checked, legal 1 or 2
// PORTS
//  sys_clk       in   1          single clock; all logic on posedge
//  sys_rst       in   1          synchronous, active-high reset
//  baud_tickH    in   1          1-cycle enable at OVERSAMPLE x baud rate
//  uart_dataH    in   1          asynchronous serial line, idle high
//  rec_dataH     out  DATA_BITS  received word, stable while rec_validH=1
//  rec_validH    out  1          holding register full
//  rec_readyH    in   1          consumer accepts word when valid&ready
//  frame_errH    out  1          word's stop bit(s) sampled low; qualified by rec_validH
//  parity_errH   out  1          word's parity mismatch; qualified by rec_validH; 0 if PARITY_EN=0
//  overrun_errH  out  1          1-cycle pulse: completed frame dropped, holding reg full
//  busyH         out  1          1 whenever state != R_IDLE
// BEHAVIOUR
//  Reset: every output and register is 0, except the sync flops, which reset to 1 (line idle). State = R_IDLE.
//  Reset mid-frame aborts the frame. No word and no error flag is produced for that frame.
//  Input path: 2-flop synchroniser on every sys_clk. The FSM uses only the second flop (lineS).
//  The tick counter tcnt advances only on cycles with baud_tickH=1. The FSM never advances without a tick.
//  The tick counter is $clog2(OVERSAMPLE) bits wide, resets to 0 on every state change, and never wraps inside a state.
//  R_IDLE: when lineS=0 on a tick, go to R_START and set tcnt=0.
//  R_START: at tcnt==OVERSAMPLE/2-1 (mid start bit), go to R_DATA if lineS=0. Otherwise the start was a glitch: go to R_IDLE.
//  R_DATA: sample every OVERSAMPLE ticks at mid-bit and shift in from the MSB end.
//    After DATA_BITS samples, go to R_PARITY if PARITY_EN=1, else go to R_STOP.
//  R_PARITY: at mid-bit, compute perr = (^data ^ bit ^ PARITY_ODD). Then go to R_STOP.
//  R_STOP: sample STOP_BITS bits at mid-bit. ferr = any stop sample equal to 0.
//    On the last stop sample, the frame completes:
//    - go to R_IDLE if ferr=0, else go to R_BREAK;
//    - the next start edge can be detected from the following tick.
//  R_BREAK: wait until lineS=1 on a tick, then go to R_IDLE. A line held low never yields a second word.
//  Frame completion is registered and appears on the next sys_clk.
//    Latency is 1 cycle from the completing tick to rec_validH=1.
//  Completion with holding register empty (or freed the same cycle, valid&ready=1):
//    load rec_dataH, frame_errH and parity_errH together; rec_validH=1.
//  Completion with rec_validH=1 and rec_readyH=0: drop the new frame.
//    Old data and flags remain unchanged. overrun_errH pulses for 1 cycle.
//  valid&ready with no completion: rec_validH=0 next cycle. rec_dataH holds its last value.
//  rec_validH never drops without a handshake, except on reset.
//  Errored frames are still delivered. The consumer decides whether to discard them.
// TESTING (OVERSAMPLE=16, baud_tickH=1 every cycle unless stated)
//  8N1: frame 0xA5 -> rec_validH=1, rec_dataH=8'hA5, errors 0; valid held until rec_readyH=1.
//  8E1 (PARITY_EN=1): send 0x03 with parity 1 -> parity_errH=1, rec_dataH=8'h03.
//    Send 0x03 with parity 0 -> parity_errH=0.
//  Line low 6 ticks, then high -> glitch rejected, no rec_validH, FSM back to R_IDLE.
//  Line held low for 3 frame times -> exactly one word 0x00 with frame_errH=1.
//    busyH=1 until line returns high.
//  Two back-to-back frames 0x11, 0x22 with rec_readyH=0 -> rec_dataH=0x11 kept.
//    overrun_errH pulses once; rec_readyH=1 then gives valid=0.
//  DATA_BITS=7, STOP_BITS=2, baud_tickH every 3rd cycle: 0x55 with 2nd stop low -> frame_errH=1.
//    Assert sys_rst mid-frame -> all outputs 0, no word.

Source files
------------

// File: rtl/u_rec_gen2.sv
`default_nettype none
// ============================================================================
//  Module   : u_rec_gen2
//  Purpose  : Parametrised oversampling UART receiver. Recovers frames of
//             DATA_BITS data bits (LSB first), optional parity and 1 or 2
//             stop bits, and hands each word to the host through a
//             valid/ready holding register together with framing and parity
//             flags. A frame that completes while the holding register is
//             still full is dropped and reported as an overrun pulse.
//  Ports    : sys_clk      - single clock, all logic on rising edge
//             sys_rst      - synchronous active-high reset
//             baud_tickH   - one-cycle enable at OVERSAMPLE x baud rate
//             uart_dataH   - asynchronous serial input, idle high
//             rec_dataH    - received word, stable while rec_validH=1
//             rec_validH   - holding register full
//             rec_readyH   - consumer accepts word on valid & ready
//             frame_errH   - stop bit(s) sampled low, qualified by valid
//             parity_errH  - parity mismatch, qualified by valid
//             overrun_errH - one-cycle pulse: completed frame dropped
//             busyH        - receiver FSM not idle
//  Revision : 1.0 - initial release
// ============================================================================
module u_rec_gen2 #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 baud_tickH,
    input  logic                 uart_dataH,
    output logic [DATA_BITS-1:0] rec_dataH,
    output logic                 rec_validH,
    input  logic                 rec_readyH,
    output logic                 frame_errH,
    output logic                 parity_errH,
    output logic                 overrun_errH,
    output logic                 busyH
);

    localparam int TW = $clog2(OVERSAMPLE);

    // Tick counter compare points: half a bit for the start-bit centre,
    // a full bit for every subsequent mid-bit sample.
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic          P_ODD  = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        R_IDLE   = 3'd0,
        R_START  = 3'd1,
        R_DATA   = 3'd2,
        R_PARITY = 3'd3,
        R_STOP   = 3'd4,
        R_BREAK  = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   sync1_q;
    logic                   line_s_q;
    logic [TW-1:0]          tcnt_q;
    logic [3:0]             bit_cnt_q;
    logic                   stop_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   ferr_q;
    logic                   perr_q;

    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   parity_err_q;
    logic                   overrun_q;

    logic                   frame_done_d;
    logic                   frame_ferr_d;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; resets to the idle (high) line level so a
    // reset never looks like a start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q  <= 1'b1;
            line_s_q <= 1'b1;
        end else begin
            sync1_q  <= uart_dataH;
            line_s_q <= sync1_q;
        end
    end

    // The last stop sample completes the frame; its framing status must
    // include the sample taken on this very tick.
    always_comb begin
        frame_done_d = baud_tickH && (state_q == R_STOP) &&
                       (tcnt_q == T_FULL) && (stop_cnt_q == S_LAST);
        frame_ferr_d = ferr_q | ~line_s_q;
    end

    // ------------------------------------------------------------------
    // Receive FSM. Everything advances only on baud ticks. The tick
    // counter is cleared on every state change and after each mid-bit
    // sample, so it never rolls over by itself.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= R_IDLE;
            tcnt_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else if (baud_tickH) begin
            case (state_q)
                R_IDLE: begin
                    if (!line_s_q) begin
                        state_q    <= R_START;
                        tcnt_q     <= '0;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        ferr_q     <= 1'b0;
                        perr_q     <= 1'b0;
                    end
                end
                R_START: begin
                    if (tcnt_q == T_MID) begin
                        tcnt_q  <= '0;
                        // A start bit that is high again at its centre was noise.
                        state_q <= line_s_q ? R_IDLE : R_DATA;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_q  <= '0;
                        // LSB arrives first, so shifting in at the MSB end
                        // leaves the word right-aligned after DATA_BITS samples.
                        shift_q <= {line_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == B_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY_EN != 0) ? R_PARITY : R_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                R_PARITY: begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_q  <= '0;
                        perr_q  <= (^shift_q) ^ line_s_q ^ P_ODD;
                        state_q <= R_STOP;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_q <= '0;
                        if (stop_cnt_q == S_LAST) begin
                            stop_cnt_q <= 1'b0;
                            ferr_q     <= frame_ferr_d;
                            // A low stop bit may be a break: wait for the line
                            // to go high before hunting for a new start edge.
                            state_q    <= frame_ferr_d ? R_BREAK : R_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                            ferr_q     <= frame_ferr_d;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                R_BREAK: begin
                    if (line_s_q) begin
                        state_q <= R_IDLE;
                        tcnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                    tcnt_q  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Holding register. A completing frame is accepted if the register is
    // empty or is being emptied in the same cycle; otherwise it is dropped
    // and the old word and its flags are left untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (frame_done_d) begin
                if (!valid_q || rec_readyH) begin
                    data_q       <= shift_q;
                    frame_err_q  <= frame_ferr_d;
                    parity_err_q <= perr_q;
                    valid_q      <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && rec_readyH) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rec_dataH    = data_q;
    assign rec_validH   = valid_q;
    assign frame_errH   = frame_err_q;
    assign parity_errH  = parity_err_q;
    assign overrun_errH = overrun_q;
    assign busyH        = (state_q != R_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_u_rec_gen2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_u_rec_gen2
//  Purpose  : Self-checking bench for u_rec_gen2. Three receivers are built:
//             A = 8N1, B = 8E1 (both ticking every cycle) and C = 7N2 with a
//             baud tick every third cycle. Frames are serialised by a task;
//             expected words are queued when a frame is driven and compared
//             when the receiver hands the word over.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_u_rec_gen2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
    logic tick_ab = 1'b1;
    logic tick_c = 1'b0;
    int   tdiv = 0;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic valid_a, valid_b, valid_c;
    logic ferr_a, ferr_b, ferr_c;
    logic perr_a, perr_b, perr_c;
    logic ovr_a, ovr_b, ovr_c;
    logic busy_a, busy_b, busy_c;

    u_rec_gen2 #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .baud_tickH(tick_ab), .uart_dataH(line_a),
        .rec_dataH(data_a), .rec_validH(valid_a), .rec_readyH(ready_a),
        .frame_errH(ferr_a), .parity_errH(perr_a), .overrun_errH(ovr_a), .busyH(busy_a));

    u_rec_gen2 #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .baud_tickH(tick_ab), .uart_dataH(line_b),
        .rec_dataH(data_b), .rec_validH(valid_b), .rec_readyH(ready_b),
        .frame_errH(ferr_b), .parity_errH(perr_b), .overrun_errH(ovr_b), .busyH(busy_b));

    u_rec_gen2 #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
        .sys_clk(clk), .sys_rst(rst), .baud_tickH(tick_c), .uart_dataH(line_c),
        .rec_dataH(data_c), .rec_validH(valid_c), .rec_readyH(ready_c),
        .frame_errH(ferr_c), .parity_errH(perr_c), .overrun_errH(ovr_c), .busyH(busy_c));

    // Baud tick for receiver C: one cycle in three.
    always @(negedge clk) begin
        tdiv   = (tdiv == 2) ? 0 : tdiv + 1;
        tick_c = (tdiv == 0);
    end

    // Per-instance views of the outputs.
    logic [2:0] v_all, r_all, f_all, p_all, o_all, b_all;
    logic [8:0] d_all [3];
    always_comb begin
        v_all = {valid_c, valid_b, valid_a};
        r_all = {ready_c, ready_b, ready_a};
        f_all = {ferr_c, ferr_b, ferr_a};
        p_all = {perr_c, perr_b, perr_a};
        o_all = {ovr_c, ovr_b, ovr_a};
        b_all = {busy_c, busy_b, busy_a};
        d_all[0] = {1'b0, data_a};
        d_all[1] = {1'b0, data_b};
        d_all[2] = {2'b00, data_c};
    end

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par;
        logic       stop_lo;
        logic [8:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ovr_cnt = 0;

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (ovr_a) ovr_cnt++;
            for (int i = 0; i < 3; i++) begin
                if (v_all[i] && r_all[i]) begin
                    n_chk++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word inst %0d: got data %0h ferr %0b perr %0b, required no word",
                                 i, d_all[i], f_all[i], p_all[i]);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        if (e.inst != i || d_all[i] !== e.data || f_all[i] !== e.ferr || p_all[i] !== e.perr) begin
                            n_fail++;
                            $display("FAIL word inst %0d: got data %0h ferr %0b perr %0b, required inst %0d data %0h ferr %0b perr %0b",
                                     i, d_all[i], f_all[i], p_all[i], e.inst, e.data, e.ferr, e.perr);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int bit_cycles(input int inst);
        return (inst == 2) ? 48 : 16;
    endfunction

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0: line_a = v;
            1: line_b = v;
            default: line_c = v;
        endcase
    endtask

    task automatic hold_bit(input int inst, input logic v);
        set_line(inst, v);
        repeat (bit_cycles(inst)) @(negedge clk);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input logic par,
                              input logic stop_lo, input int gap_bits);
        int nbits;
        int nstop;
        nbits = (inst == 2) ? 7 : 8;
        nstop = (inst == 2) ? 2 : 1;
        hold_bit(inst, 1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(inst, data[i]);
        if (inst == 1) hold_bit(inst, par);
        for (int s = 0; s < nstop; s++) hold_bit(inst, (s == nstop - 1 && stop_lo) ? 1'b0 : 1'b1);
        set_line(inst, 1'b1);
        repeat (gap_bits * bit_cycles(inst)) @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h0FF, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0};
        vecs[3] = '{0, 9'h03C, 1'b0, 1'b1, 9'h03C, 1'b1, 1'b0};
        vecs[4] = '{1, 9'h003, 1'b1, 1'b0, 9'h003, 1'b0, 1'b1};
        vecs[5] = '{1, 9'h003, 1'b0, 1'b0, 9'h003, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h080, 1'b1, 1'b0, 9'h080, 1'b0, 1'b0};
        vecs[7] = '{1, 9'h080, 1'b0, 1'b0, 9'h080, 1'b0, 1'b1};
        vecs[8] = '{2, 9'h055, 1'b0, 1'b1, 9'h055, 1'b1, 1'b0};
        vecs[9] = '{2, 9'h02A, 1'b0, 1'b0, 9'h02A, 1'b0, 1'b0};

        // Reset state of all three receivers.
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_valid%0d", i), {31'b0, v_all[i]}, 32'd0);
            check($sformatf("reset_data%0d", i), {23'b0, d_all[i]}, 32'd0);
            check($sformatf("reset_ferr%0d", i), {31'b0, f_all[i]}, 32'd0);
            check($sformatf("reset_perr%0d", i), {31'b0, p_all[i]}, 32'd0);
            check($sformatf("reset_ovr%0d", i), {31'b0, o_all[i]}, 32'd0);
            check($sformatf("reset_busy%0d", i), {31'b0, b_all[i]}, 32'd0);
        end
        repeat (20) @(negedge clk);

        // Table-driven frames with the consumer always ready.
        for (int k = 0; k < 10; k++) begin
            q.push_back('{vecs[k].inst, vecs[k].exp_data, vecs[k].exp_ferr, vecs[k].exp_perr});
            send_frame(vecs[k].inst, vecs[k].data, vecs[k].par, vecs[k].stop_lo, 2);
        end

        // Word held until the consumer becomes ready.
        ready_a = 1'b0;
        q.push_back('{0, 9'h0A5, 1'b0, 1'b0});
        send_frame(0, 9'h0A5, 1'b0, 1'b0, 2);
        repeat (100) @(negedge clk);
        check("hold_valid", {31'b0, valid_a}, 32'd1);
        check("hold_data", {24'b0, data_a}, 32'h0A5);
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_release", {31'b0, valid_a}, 32'd0);
        check("hold_data_kept", {24'b0, data_a}, 32'h0A5);

        // Start glitch: six cycles low, then high again.
        line_a = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", {31'b0, busy_a}, 32'd1);
        repeat (2) @(negedge clk);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_idle", {31'b0, busy_a}, 32'd0);
        check("glitch_novalid", {31'b0, valid_a}, 32'd0);

        // Line held low for three frame times: one zero word with framing error.
        q.push_back('{0, 9'h000, 1'b1, 1'b0});
        line_a = 1'b0;
        repeat (480) @(negedge clk);
        check("break_busy", {31'b0, busy_a}, 32'd1);
        line_a = 1'b1;
        repeat (40) @(negedge clk);
        check("break_idle", {31'b0, busy_a}, 32'd0);
        check("break_one_word", q.size(), 32'd0);

        // Overrun: two frames back to back with no consumer.
        ready_a = 1'b0;
        ovr_cnt = 0;
        q.push_back('{0, 9'h011, 1'b0, 1'b0});
        send_frame(0, 9'h011, 1'b0, 1'b0, 0);
        send_frame(0, 9'h022, 1'b0, 1'b0, 2);
        check("ovr_pulses", ovr_cnt, 32'd1);
        check("ovr_valid", {31'b0, valid_a}, 32'd1);
        check("ovr_data_kept", {24'b0, data_a}, 32'h011);
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_release", {31'b0, valid_a}, 32'd0);

        // Reset in the middle of a 7N2 frame on receiver C.
        hold_bit(2, 1'b0);
        hold_bit(2, 1'b1);
        hold_bit(2, 1'b0);
        hold_bit(2, 1'b1);
        check("midrst_busy_before", {31'b0, busy_c}, 32'd1);
        rst = 1'b1;
        line_c = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy_c}, 32'd0);
        check("midrst_valid", {31'b0, valid_c}, 32'd0);
        check("midrst_data", {25'b0, data_c}, 32'd0);
        check("midrst_ferr", {31'b0, ferr_c}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        check("midrst_noword", {31'b0, valid_c}, 32'd0);
        check("midrst_idle", {31'b0, busy_c}, 32'd0);

        check("scoreboard_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
